led_out_port: RTL and testbench
===============================

# led_out_port

Output peripheral of the nanoprocessor board, downstream of the processor core. Captures each byte the core emits with the OUT instruction into a small FIFO. Presents each byte on the LED bar for a fixed number of clock cycles so that successive outputs remain visible. Replaces the direct `RAM_ADDR -> LedBar` assignment in `board`.

## Interface

Parameters:
- `DEPTH`, default 4 — FIFO entries; power of two, minimum 2.
- `HOLD_CYCLES`, default 16 — cycles each byte stays on `LedBar` when the queue is backlogged; minimum 1.

Ports:
- `clk`  in  1  — single clock; every register updates on `posedge clk`.
- `reset`  in  1  — synchronous, active-high reset.
- `wr_en`  in  1  — OUT strobe from the controller; one push per asserted cycle.
- `wr_data`  in  8  — byte to output; the accumulator value.
- `full`  out  1  — FIFO holds `DEPTH` entries. Combinational from the occupancy count.
- `busy`  out  1  — high while in SHOW or while the FIFO is non-empty.
- `overflow`  out  1  — sticky; set when a push is dropped. Cleared only by `reset`.
- `LedBar`  out  8  — displayed byte.

## Operation

- Reset values:
  - `LedBar` = 0
  - `overflow` = 0
  - `full` = 0
  - `busy` = 0
  - occupancy = 0
  - read pointer = 0, write pointer = 0
  - hold counter = 0
  - state = IDLE
- FIFO:
  - Circular buffer with `DEPTH` entries.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
  - Occupancy counter is `$clog2(DEPTH)+1` bits wide.
- Push rule:
  - A push is accepted when `wr_en` is high and either occupancy < `DEPTH` or a pop occurs in the same cycle.
  - Otherwise the byte is discarded and `overflow` is set.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- State machine:
  - IDLE: if occupancy > 0, pop the head into `LedBar`, load the counter with `HOLD_CYCLES-1`, and go to SHOW. Otherwise stay in IDLE.
  - SHOW, counter ≠ 0: decrement the counter.
  - SHOW, counter = 0, occupancy > 0: pop the next byte into `LedBar`, reload `HOLD_CYCLES-1`, and stay in SHOW. There is no IDLE gap.
  - SHOW, counter = 0, occupancy = 0: go to IDLE.
- `LedBar` keeps the last displayed byte indefinitely in IDLE. It is never blanked except by `reset`.
- A pop reads the entry at the read pointer before any same-cycle write.
- When occupancy is 0, a same-cycle push is never popped in that cycle. Data passes through the FIFO; there is no bypass.

## Timing

- Push at edge k into an empty FIFO while in IDLE:
  - Occupancy = 1 after edge k.
  - `LedBar` = byte after edge k+1.
- With the queue backlogged, each byte stays on `LedBar` exactly `HOLD_CYCLES` cycles.
- `HOLD_CYCLES` = 1: a new byte appears on every cycle while the FIFO is non-empty.
- `full` and `busy` reflect register state after the current edge. There is no combinational path from `wr_en`.
- `reset` mid-operation:
  - All queued bytes are discarded.
  - Every output returns to its reset value at the next edge.
  - `reset` has priority over `wr_en`.

## Structure

- Shared package `nanop_pkg`:
  - Instruction opcode localparams, including `OUT` = `8'b0000_1100`.
  - Typedef `led_state_t` enum {IDLE, SHOW}.
- Sub-module `fifo_sync #(WIDTH, DEPTH)`:
  - Storage, pointers, occupancy, `full`, `empty`.
  - `push`/`pop` inputs; `pop` is only asserted by the FSM when the FIFO is non-empty.
- `led_out_port` holds the FSM, the hold counter, the `LedBar` register and the `overflow` flag.

## Test plan

1. Reset behaviour: assert `reset` for 2 cycles with `wr_en` high and `wr_data` = 8'hFF. Required: `LedBar` = 0, `full` = 0, `busy` = 0, `overflow` = 0.
2. Single push: push 8'd25 once with `HOLD_CYCLES` = 16. Required:
   - `LedBar` = 25 two edges after the push.
   - `busy` falls after 16 display cycles.
   - `LedBar` still equals 25 100 cycles later.
3. Backlog: push 3, 7, 6, 5 on consecutive cycles. Required: `LedBar` shows each value for exactly 16 cycles, in order, with no gap.
4. Overflow: with `DEPTH` = 4, push 6 bytes on consecutive cycles starting from IDLE. Required:
   - The first pop frees one slot, so 5 bytes are accepted and 1 is dropped.
   - `overflow` = 1 and stays 1.
   - `full` = 1 during the burst.
5. Simultaneous push and pop while full: present `wr_en` on the exact cycle the hold counter expires. Required: the byte is accepted, occupancy stays 4, and `overflow` is unchanged.
6. Reset mid-SHOW: with 3 bytes queued and the display halfway through its hold, assert `reset` for 1 cycle. Required: `LedBar` = 0 and `busy` = 0 on the next edge; no queued byte appears afterwards.

Source files
------------

// File: rtl/nanop_pkg.sv
// Shared definitions for the nanoprocessor board: instruction opcodes and
// the LED output port state type.
package nanop_pkg;

    localparam int unsigned OPCODE_W = 8;

    localparam logic [OPCODE_W-1:0] NOP  = 8'b0000_0000;
    localparam logic [OPCODE_W-1:0] LDI  = 8'b0000_0001;
    localparam logic [OPCODE_W-1:0] ADD  = 8'b0000_0010;
    localparam logic [OPCODE_W-1:0] SUB  = 8'b0000_0011;
    localparam logic [OPCODE_W-1:0] JMP  = 8'b0000_0100;
    localparam logic [OPCODE_W-1:0] JZ   = 8'b0000_0101;
    localparam logic [OPCODE_W-1:0] OUT  = 8'b0000_1100;
    localparam logic [OPCODE_W-1:0] HALT = 8'b0000_1111;

    localparam int unsigned LED_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } led_state_t;

    // Hold-counter width; at least one bit so HOLD_CYCLES = 1 still elaborates.
    function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
        return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock circular FIFO with occupancy counter. The head entry is
// presented combinationally so a pop sees it before any same-cycle write.
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);

endmodule

// File: rtl/led_out_port.sv
// LED output port: queues OUT bytes and shows each on LedBar for
// HOLD_CYCLES cycles, back to back while the queue is backlogged.
module led_out_port
    import nanop_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [LED_W-1:0] wr_data,
    output logic             full,
    output logic             busy,
    output logic             overflow,
    output logic [LED_W-1:0] LedBar
);

    localparam int unsigned CNT_W = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    led_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [LED_W-1:0] r_led;
    logic             r_ovf;

    led_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [LED_W-1:0] w_led_nxt;
    logic             w_ovf_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [LED_W-1:0] w_head;

    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign w_push = wr_en && (!w_full || w_pop);

    fifo_sync #(
        .WIDTH (LED_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (wr_data),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_led   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_led   <= w_led_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state, hold counter and display update; pops only when non-empty.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_led_nxt   = r_led;
        w_pop       = 1'b0;
        w_ovf_nxt   = r_ovf || (wr_en && !w_push);

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_led_nxt   = w_head;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_led_nxt = w_head;
                    w_cnt_nxt = HOLD_LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign full     = w_full;
    assign busy     = (r_state == SHOW) || !w_empty;
    assign overflow = r_ovf;
    assign LedBar   = r_led;

endmodule

// File: tb/tb_led_out_port.sv
// Directed bench for led_out_port with DEPTH = 4, HOLD_CYCLES = 16.
module tb_led_out_port;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       busy;
    logic       overflow;
    logic [7:0] LedBar;

    int n_checks;
    int n_errors;

    led_out_port #(
        .DEPTH       (4),
        .HOLD_CYCLES (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .LedBar   (LedBar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    logic [7:0] v3 [4];
    logic [7:0] v5 [6];
    logic [7:0] exp_led;
    int idx;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        v3 = '{8'd3, 8'd7, 8'd6, 8'd5};
        v5 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        #2;

        // 1: reset dominates a pending write
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        step();
        step();
        check("rst_led", 32'(LedBar), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        wr_en = 1'b0;
        step();
        check("rst_nopush", 32'(busy), 32'h0);

        // 2: single push of 25, edge k
        wr_data = 8'd25;
        wr_en   = 1'b1;
        step();
        wr_en = 1'b0;
        check("single_k_busy", 32'(busy), 32'h1);
        check("single_k_led", 32'(LedBar), 32'h0);
        step();
        check("single_k1_led", 32'(LedBar), 32'd25);
        repeat (15) step();
        check("single_k16_busy", 32'(busy), 32'h1);
        check("single_k16_led", 32'(LedBar), 32'd25);
        step();
        check("single_k17_busy", 32'(busy), 32'h0);
        repeat (100) step();
        check("single_hold_led", 32'(LedBar), 32'd25);
        check("single_hold_busy", 32'(busy), 32'h0);

        // 3: backlog of four bytes, 16 cycles each, no gap
        for (int j = 0; j < 70; j++) begin
            wr_en   = (j < 4);
            wr_data = (j < 4) ? v3[j] : 8'h00;
            step();
            if (j == 0) exp_led = 8'd25;
            else begin
                idx = (j - 1) / 16;
                exp_led = v3[(idx > 3) ? 3 : idx];
            end
            check($sformatf("backlog_led_%0d", j), 32'(LedBar), 32'(exp_led));
            check($sformatf("backlog_busy_%0d", j), 32'(busy), (j <= 64) ? 32'h1 : 32'h0);
        end
        wr_en = 1'b0;

        // 4: six-byte burst into depth 4; first pop frees a slot, sixth byte dropped
        for (int j = 0; j < 90; j++) begin
            wr_en   = (j < 6);
            wr_data = 8'h11 + 8'(j);
            step();
            if (j == 0) exp_led = 8'd5;
            else begin
                idx = (j - 1) / 16;
                exp_led = 8'h11 + 8'((idx > 4) ? 4 : idx);
            end
            check($sformatf("ovf_led_%0d", j), 32'(LedBar), 32'(exp_led));
            check($sformatf("ovf_flag_%0d", j), 32'(overflow), (j >= 5) ? 32'h1 : 32'h0);
            check($sformatf("ovf_busy_%0d", j), 32'(busy), (j <= 80) ? 32'h1 : 32'h0);
            if (j >= 3 && j <= 5)
                check($sformatf("ovf_full_%0d", j), 32'(full), (j >= 4) ? 32'h1 : 32'h0);
        end
        wr_en = 1'b0;

        // 5: push on the expiry edge while full is accepted, occupancy stays 4
        do_reset();
        check("sim_rst_ovf", 32'(overflow), 32'h0);
        for (int j = 0; j < 100; j++) begin
            wr_en   = (j < 5) || (j == 17);
            wr_data = (j < 5) ? v5[j] : v5[5];
            step();
            if (j == 0) exp_led = 8'h00;
            else begin
                idx = (j - 1) / 16;
                exp_led = v5[(idx > 5) ? 5 : idx];
            end
            check($sformatf("sim_led_%0d", j), 32'(LedBar), 32'(exp_led));
            check($sformatf("sim_ovf_%0d", j), 32'(overflow), 32'h0);
            check($sformatf("sim_full_%0d", j), 32'(full), (j >= 4 && j <= 32) ? 32'h1 : 32'h0);
        end
        wr_en = 1'b0;

        // 6: reset mid-SHOW with three bytes queued discards them
        do_reset();
        for (int j = 0; j < 9; j++) begin
            wr_en   = (j < 4);
            wr_data = 8'hC0 + 8'(j);
            step();
        end
        wr_en = 1'b0;
        check("midrst_pre_led", 32'(LedBar), 32'hC0);
        check("midrst_pre_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_led", 32'(LedBar), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_full", 32'(full), 32'h0);
        for (int j = 0; j < 40; j++) begin
            step();
            check($sformatf("midrst_after_led_%0d", j), 32'(LedBar), 32'h0);
            check($sformatf("midrst_after_busy_%0d", j), 32'(busy), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
